// File: rtl/data_c_scaler_sched_if.sv
// ----------------------------------------------------------------------------
// data_c_scaler_sched_if
//   Bundles the scheduler's frame-config handshake, the three stream beat taps
//   and the strobes that go back to the head/body/end concatenator.
//
//   Signals (seen from the scheduler, modport slave):
//     cfg_valid        in   frame config offered
//     cfg_ready        out  config can be taken (no pending frame held)
//     cfg_*_len_m1     in   per-phase beat count minus one
//     *_vld_rdy        in   a beat was transferred on head/body/end stream
//     trigger          out  concatenator trigger
//     head/body/end_last out next beat on that stream closes its phase
//     frame_done       out  1-cycle pulse after a frame's final beat
//     busy             out  scheduler not idle
//     proto_err        out  1-cycle pulse after a stray beat
// ----------------------------------------------------------------------------
interface data_c_scaler_sched_if #(
    parameter int LSIZE = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [LSIZE-1:0] cfg_head_len_m1;
    logic [LSIZE-1:0] cfg_body_len_m1;
    logic [LSIZE-1:0] cfg_end_len_m1;
    logic             head_vld_rdy;
    logic             body_vld_rdy;
    logic             end_vld_rdy;
    logic             trigger;
    logic             head_last;
    logic             body_last;
    logic             end_last;
    logic             frame_done;
    logic             busy;
    logic             proto_err;

    // Driver side: offers configs, reports stream beats, observes strobes.
    modport master (
        output cfg_valid, cfg_head_len_m1, cfg_body_len_m1, cfg_end_len_m1,
        output head_vld_rdy, body_vld_rdy, end_vld_rdy,
        input  cfg_ready, trigger, head_last, body_last, end_last,
        input  frame_done, busy, proto_err
    );

    // Scheduler side.
    modport slave (
        input  cfg_valid, cfg_head_len_m1, cfg_body_len_m1, cfg_end_len_m1,
        input  head_vld_rdy, body_vld_rdy, end_vld_rdy,
        output cfg_ready, trigger, head_last, body_last, end_last,
        output frame_done, busy, proto_err
    );
endinterface

// File: rtl/data_c_scaler_sched.sv
// ----------------------------------------------------------------------------
// data_c_scaler_sched
//   Frame scheduler for the head/body/end stream concatenator. Holds one
//   active and one pending frame configuration, tracks the beat count of the
//   current phase, and drives the concatenator trigger and per-stream *_last
//   strobes. Beats arriving on a stream outside the current phase are flagged
//   on proto_err and otherwise ignored.
//
//   Parameters:
//     MODE   "BOTH" -> HEAD,BODY,END  "HEAD" -> HEAD,BODY  "END" -> BODY,END
//     LSIZE  width of the length fields and of the beat counter
//
//   Ports:
//     clock  in   single clock domain
//     rst    in   synchronous active-high reset
//     bus    slave modport of data_c_scaler_sched_if (config, taps, strobes)
// ----------------------------------------------------------------------------
module data_c_scaler_sched #(
    parameter string MODE  = "BOTH",
    parameter int    LSIZE = 16
) (
    input  logic                 clock,
    input  logic                 rst,
    data_c_scaler_sched_if.slave bus
);
    localparam bit HAS_HEAD = (MODE != "END");
    localparam bit HAS_END  = (MODE != "HEAD");

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_HEAD,
        ST_BODY,
        ST_END
    } state_t;

    typedef struct packed {
        logic [LSIZE-1:0] head_m1;
        logic [LSIZE-1:0] body_m1;
        logic [LSIZE-1:0] end_m1;
    } lens_t;

    state_t           state_q, state_d;
    logic [LSIZE-1:0] cnt_q, cnt_d;
    lens_t            act_q, act_d;
    lens_t            pend_q, pend_d;
    logic             pend_vld_q, pend_vld_d;
    logic             frame_done_q, frame_done_d;
    logic             proto_err_q, proto_err_d;

    state_t           first_st;    // phase that opens a frame
    state_t           final_st;    // phase that closes a frame
    state_t           phase;       // current phase, ARM resolved to first_st
    state_t           next_phase;  // phase following a non-final phase
    logic [LSIZE-1:0] phase_len;
    logic             hit;         // beat on the stream of the current phase
    logic             stray;
    logic             last_beat;
    logic             final_done;
    logic             accept;
    lens_t            cfg_lens;

    // ------------------------------------------------------------------
    // Phase decode, beat classification
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        first_st   = ST_BODY;
        final_st   = ST_BODY;
        phase      = state_q;
        next_phase = ST_END;
        phase_len  = '0;
        hit        = 1'b0;

        if (HAS_HEAD) first_st = ST_HEAD;
        if (HAS_END)  final_st = ST_END;

        // ARM waits for the first beat of the opening phase, so it behaves
        // like that phase for matching, counting and *_last purposes.
        if (state_q == ST_ARM) phase = first_st;
        if (phase == ST_HEAD)  next_phase = ST_BODY;

        case (phase)
            ST_HEAD: begin phase_len = act_q.head_m1; hit = bus.head_vld_rdy; end
            ST_BODY: begin phase_len = act_q.body_m1; hit = bus.body_vld_rdy; end
            ST_END:  begin phase_len = act_q.end_m1;  hit = bus.end_vld_rdy;  end
            default: ;
        endcase
    end

    // In IDLE the phase is IDLE, so every beat counts as stray. Streams the
    // MODE never schedules can never match and are always stray.
    assign stray = (bus.head_vld_rdy && (phase != ST_HEAD)) ||
                   (bus.body_vld_rdy && (phase != ST_BODY)) ||
                   (bus.end_vld_rdy  && (phase != ST_END));

    assign last_beat  = hit && (cnt_q == phase_len);
    assign final_done = last_beat && (phase == final_st);
    assign accept     = bus.cfg_valid && !pend_vld_q;
    assign cfg_lens   = '{head_m1: bus.cfg_head_len_m1,
                          body_m1: bus.cfg_body_len_m1,
                          end_m1:  bus.cfg_end_len_m1};

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_d        = act_q;
        pend_d       = pend_q;
        pend_vld_d   = pend_vld_q;
        frame_done_d = final_done;
        proto_err_d  = stray;

        if (state_q == ST_IDLE) begin
            if (accept) begin
                act_d   = cfg_lens;
                state_d = ST_ARM;
            end
        end else if (final_done) begin
            cnt_d = '0;
            if (pend_vld_q) begin
                // cfg_ready is low here, so no new config competes.
                act_d      = pend_q;
                pend_vld_d = 1'b0;
                state_d    = ST_ARM;
            end else if (accept) begin
                act_d   = cfg_lens;
                state_d = ST_ARM;
            end else begin
                state_d = ST_IDLE;
            end
        end else begin
            if (last_beat) begin
                state_d = next_phase;
                cnt_d   = '0;
            end else if (hit) begin
                // cnt_q < phase_len here, so the counter cannot wrap.
                state_d = phase;
                cnt_d   = cnt_q + LSIZE'(1);
            end
            if (accept) begin
                pend_d     = cfg_lens;
                pend_vld_d = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            act_q        <= '0;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_q        <= act_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            frame_done_q <= frame_done_d;
            proto_err_q  <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.cfg_ready  = !pend_vld_q;
    // Raising trigger during the final phase when a frame is queued lets the
    // concatenator reopen the first stream as soon as it finishes.
    assign bus.trigger    = (state_q == ST_ARM) || ((state_q == final_st) && pend_vld_q);
    assign bus.head_last  = (phase == ST_HEAD) && (cnt_q == act_q.head_m1);
    assign bus.body_last  = (phase == ST_BODY) && (cnt_q == act_q.body_m1);
    assign bus.end_last   = (phase == ST_END)  && (cnt_q == act_q.end_m1);
    assign bus.frame_done = frame_done_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.proto_err  = proto_err_q;
endmodule

// File: tb/tb_data_c_scaler_sched.sv
// ----------------------------------------------------------------------------
// tb_data_c_scaler_sched
//   Bench for data_c_scaler_sched. Three instances (MODE BOTH, HEAD, END)
//   share stimulus; md selects which one is driven and observed. Directed
//   scenarios use constant expectations; the random scenario compares every
//   cycle against a frame model kept as a queue of expected beats.
// ----------------------------------------------------------------------------
module tb_data_c_scaler_sched;
    localparam int LS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    int            md  = 0;          // 0 BOTH, 1 HEAD, 2 END
    logic          cfg_valid = 1'b0;
    logic [LS-1:0] c_h = '0, c_b = '0, c_e = '0;
    logic [2:0]    vr = '0;          // {end, body, head} beat taps

    int n_pass  = 0;
    int n_total = 0;

    data_c_scaler_sched_if #(.LSIZE(LS)) if_b ();
    data_c_scaler_sched_if #(.LSIZE(LS)) if_h ();
    data_c_scaler_sched_if #(.LSIZE(LS)) if_e ();

    assign if_b.cfg_valid = cfg_valid && (md == 0);
    assign if_b.cfg_head_len_m1 = c_h;
    assign if_b.cfg_body_len_m1 = c_b;
    assign if_b.cfg_end_len_m1  = c_e;
    assign if_b.head_vld_rdy = vr[0] && (md == 0);
    assign if_b.body_vld_rdy = vr[1] && (md == 0);
    assign if_b.end_vld_rdy  = vr[2] && (md == 0);

    assign if_h.cfg_valid = cfg_valid && (md == 1);
    assign if_h.cfg_head_len_m1 = c_h;
    assign if_h.cfg_body_len_m1 = c_b;
    assign if_h.cfg_end_len_m1  = c_e;
    assign if_h.head_vld_rdy = vr[0] && (md == 1);
    assign if_h.body_vld_rdy = vr[1] && (md == 1);
    assign if_h.end_vld_rdy  = vr[2] && (md == 1);

    assign if_e.cfg_valid = cfg_valid && (md == 2);
    assign if_e.cfg_head_len_m1 = c_h;
    assign if_e.cfg_body_len_m1 = c_b;
    assign if_e.cfg_end_len_m1  = c_e;
    assign if_e.head_vld_rdy = vr[0] && (md == 2);
    assign if_e.body_vld_rdy = vr[1] && (md == 2);
    assign if_e.end_vld_rdy  = vr[2] && (md == 2);

    data_c_scaler_sched #(.MODE("BOTH"), .LSIZE(LS)) dut_b (.clock(clk), .rst(rst), .bus(if_b));
    data_c_scaler_sched #(.MODE("HEAD"), .LSIZE(LS)) dut_h (.clock(clk), .rst(rst), .bus(if_h));
    data_c_scaler_sched #(.MODE("END"),  .LSIZE(LS)) dut_e (.clock(clk), .rst(rst), .bus(if_e));

    // Observed vector: {cfg_ready, trigger, head_last, body_last, end_last,
    //                   frame_done, busy, proto_err}
    logic [7:0] ob, oh, oe, obs;
    assign ob = {if_b.cfg_ready, if_b.trigger, if_b.head_last, if_b.body_last,
                 if_b.end_last, if_b.frame_done, if_b.busy, if_b.proto_err};
    assign oh = {if_h.cfg_ready, if_h.trigger, if_h.head_last, if_h.body_last,
                 if_h.end_last, if_h.frame_done, if_h.busy, if_h.proto_err};
    assign oe = {if_e.cfg_ready, if_e.trigger, if_e.head_last, if_e.body_last,
                 if_e.end_last, if_e.frame_done, if_e.busy, if_e.proto_err};
    assign obs = (md == 0) ? ob : (md == 1) ? oh : oe;

    logic o_rdy, o_trig, o_hl, o_bl, o_el, o_done, o_busy, o_err;
    assign {o_rdy, o_trig, o_hl, o_bl, o_el, o_done, o_busy, o_err} = obs;

    // ------------------------------------------------------------------
    // Reference model: queue of every beat still owed by the accepted
    // frames, in stream order.
    // ------------------------------------------------------------------
    typedef struct {
        int s;       // 0 head, 1 body, 2 end
        bit plast;   // last beat of its phase
        bit ffirst;  // first beat of its frame
        bit ffinal;  // last beat of its frame
    } beat_t;

    beat_t mq[$];
    int    nfr;     // frames held (active + pending)
    bit    m_done;
    bit    m_err;

    task automatic model_clear();
        mq.delete();
        nfr    = 0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_push(input int h, input int b, input int e);
        int    lens[3];
        bit    used[3];
        int    fin;
        bit    first;
        beat_t bt;
        lens  = '{h, b, e};
        used  = '{md != 2, 1'b1, md != 1};
        fin   = (md == 1) ? 1 : 2;
        first = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (used[s]) begin
                for (int k = 0; k <= lens[s]; k++) begin
                    bt.s      = s;
                    bt.plast  = (k == lens[s]);
                    bt.ffirst = first;
                    bt.ffinal = (s == fin) && (k == lens[s]);
                    mq.push_back(bt);
                    first = 1'b0;
                end
            end
        end
        nfr++;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; vr = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_cfg(input int h, input int b, input int e);
        cfg_valid = 1'b1;
        c_h = LS'(h); c_b = LS'(b); c_e = LS'(e);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic beat(input int s);
        vr = '0;
        vr[s] = 1'b1;
        tick();
        vr = '0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        for (int m = 0; m < 3; m++) begin
            md = m;
            do_reset();
            n_total++;
            if (obs !== 8'b1000_0000) $display("FAIL reset_md%0d got=%b exp=10000000", m, obs);
            else n_pass++;
        end
    endtask

    task automatic test_single_frame();
        md = 0; do_reset();
        send_cfg(2, 3, 1);
        n_total++; if (o_trig !== 1'b1) $display("FAIL t1_arm_trig got=%b exp=1", o_trig); else n_pass++;
        n_total++; if (o_busy !== 1'b1) $display("FAIL t1_busy got=%b exp=1", o_busy); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++; if (o_hl !== (i == 2)) $display("FAIL t1_head_last%0d got=%b exp=%b", i, o_hl, i == 2); else n_pass++;
            beat(0);
        end
        n_total++; if (o_trig !== 1'b0) $display("FAIL t1_body_trig got=%b exp=0", o_trig); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++; if (o_bl !== (i == 3)) $display("FAIL t1_body_last%0d got=%b exp=%b", i, o_bl, i == 3); else n_pass++;
            beat(1);
        end
        for (int i = 0; i < 2; i++) begin
            n_total++; if (o_el !== (i == 1)) $display("FAIL t1_end_last%0d got=%b exp=%b", i, o_el, i == 1); else n_pass++;
            beat(2);
        end
        n_total++; if (o_done !== 1'b1) $display("FAIL t1_done got=%b exp=1", o_done); else n_pass++;
        n_total++; if (o_busy !== 1'b0) $display("FAIL t1_busy_fall got=%b exp=0", o_busy); else n_pass++;
        tick();
        n_total++; if (o_done !== 1'b0) $display("FAIL t1_done_pulse got=%b exp=0", o_done); else n_pass++;
    endtask

    task automatic test_back_to_back();
        md = 0; do_reset();
        send_cfg(1, 0, 0);                       // frame A
        n_total++; if (o_rdy !== 1'b1) $display("FAIL t2_rdy_arm got=%b exp=1", o_rdy); else n_pass++;
        send_cfg(0, 0, 1);                       // frame B, held pending
        n_total++; if (o_rdy !== 1'b0) $display("FAIL t2_rdy_pend got=%b exp=0", o_rdy); else n_pass++;
        beat(0); beat(0); beat(1);
        n_total++; if (o_trig !== 1'b1) $display("FAIL t2_final_trig got=%b exp=1", o_trig); else n_pass++;
        n_total++; if (o_rdy !== 1'b0) $display("FAIL t2_rdy_final got=%b exp=0", o_rdy); else n_pass++;
        beat(2);                                 // A done, B promoted
        n_total++; if (obs !== 8'b1110_0110) $display("FAIL t2_promote got=%b exp=11100110", obs); else n_pass++;
        beat(0); beat(1);
        n_total++; if (o_el !== 1'b0) $display("FAIL t2_b_end0 got=%b exp=0", o_el); else n_pass++;
        beat(2);
        n_total++; if (o_el !== 1'b1) $display("FAIL t2_b_end1 got=%b exp=1", o_el); else n_pass++;
        beat(2);
        n_total++; if ({o_done, o_busy} !== 2'b10) $display("FAIL t2_b_done got=%b exp=10", {o_done, o_busy}); else n_pass++;
    endtask

    task automatic test_zero_len();
        md = 0; do_reset();
        send_cfg(0, 0, 0);
        n_total++; if ({o_hl, o_bl, o_el} !== 3'b100) $display("FAIL t3_arm_last got=%b exp=100", {o_hl, o_bl, o_el}); else n_pass++;
        beat(0);
        n_total++; if ({o_hl, o_bl, o_el} !== 3'b010) $display("FAIL t3_body_last got=%b exp=010", {o_hl, o_bl, o_el}); else n_pass++;
        beat(1);
        n_total++; if ({o_hl, o_bl, o_el} !== 3'b001) $display("FAIL t3_end_last got=%b exp=001", {o_hl, o_bl, o_el}); else n_pass++;
        beat(2);
        n_total++; if ({o_done, o_busy} !== 2'b10) $display("FAIL t3_done got=%b exp=10", {o_done, o_busy}); else n_pass++;
    endtask

    task automatic test_stray();
        md = 0; do_reset();
        send_cfg(3, 0, 0);
        beat(0);
        beat(1);                                 // stray body beat in HEAD
        n_total++; if (o_err !== 1'b1) $display("FAIL t4_err got=%b exp=1", o_err); else n_pass++;
        tick();
        n_total++; if (o_err !== 1'b0) $display("FAIL t4_err_pulse got=%b exp=0", o_err); else n_pass++;
        beat(0);
        n_total++; if (o_hl !== 1'b0) $display("FAIL t4_head_cnt got=%b exp=0", o_hl); else n_pass++;
        beat(0);
        n_total++; if (o_hl !== 1'b1) $display("FAIL t4_head_last got=%b exp=1", o_hl); else n_pass++;
        beat(0); beat(1); beat(2);
        n_total++; if (o_done !== 1'b1) $display("FAIL t4_done got=%b exp=1", o_done); else n_pass++;
    endtask

    task automatic test_end_mode();
        md = 2; do_reset();
        send_cfg(7, 1, 0);
        n_total++; if ({o_trig, o_bl} !== 2'b10) $display("FAIL t5_arm got=%b exp=10", {o_trig, o_bl}); else n_pass++;
        beat(0);                                 // head beat never belongs in END mode
        n_total++; if ({o_err, o_trig} !== 2'b11) $display("FAIL t5_head_err got=%b exp=11", {o_err, o_trig}); else n_pass++;
        beat(1);
        n_total++; if ({o_trig, o_bl} !== 2'b01) $display("FAIL t5_body_last got=%b exp=01", {o_trig, o_bl}); else n_pass++;
        beat(1);
        n_total++; if ({o_trig, o_el} !== 2'b01) $display("FAIL t5_end_last got=%b exp=01", {o_trig, o_el}); else n_pass++;
        beat(2);
        n_total++; if ({o_done, o_busy} !== 2'b10) $display("FAIL t5_done got=%b exp=10", {o_done, o_busy}); else n_pass++;
    endtask

    task automatic test_reset_mid();
        md = 0; do_reset();
        send_cfg(0, 3, 0);
        send_cfg(1, 1, 1);
        beat(0); beat(1);
        n_total++; if ({o_rdy, o_busy} !== 2'b01) $display("FAIL t6_pre got=%b exp=01", {o_rdy, o_busy}); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (obs !== 8'b1000_0000) $display("FAIL t6_after_rst got=%b exp=10000000", obs); else n_pass++;
        beat(1);                                 // IDLE now, so any beat is stray
        n_total++; if ({o_err, o_busy} !== 2'b10) $display("FAIL t6_idle_stray got=%b exp=10", {o_err, o_busy}); else n_pass++;
    endtask

    task automatic test_random();
        beat_t bt;
        logic [7:0] expv;
        int  fin, cur, r;
        bit  acc, ndone, nerr;
        for (int m = 0; m < 3; m++) begin
            md = m; do_reset(); model_clear();
            fin = (m == 1) ? 1 : 2;
            for (int cyc = 0; cyc < 600; cyc++) begin
                // expected outputs from the model's current view
                expv = {nfr < 2, 1'b0, 3'b000, m_done, nfr > 0, m_err};
                if (nfr > 0) begin
                    expv[6] = mq[0].ffirst || ((mq[0].s == fin) && (nfr == 2));
                    if (mq[0].plast) expv[5 - mq[0].s] = 1'b1;
                end
                n_total++;
                if (obs !== expv) $display("FAIL rnd_md%0d_cyc%0d got=%b exp=%b", m, cyc, obs, expv);
                else n_pass++;

                // stimulus: mostly legal beats, occasional strays and configs
                cfg_valid = ($urandom_range(0, 3) == 0);
                r = $urandom_range(0, 15); c_h = LS'((r == 0) ? 15 : r % 4);
                r = $urandom_range(0, 15); c_b = LS'((r == 0) ? 15 : r % 4);
                r = $urandom_range(0, 15); c_e = LS'((r == 0) ? 15 : r % 4);
                vr  = '0;
                cur = (nfr > 0) ? mq[0].s : -1;
                if ((cur >= 0) && ($urandom_range(0, 9) < 6)) vr[cur] = 1'b1;
                if ($urandom_range(0, 15) == 0) vr[$urandom_range(0, 2)] = 1'b1;

                // model update for this edge
                acc = cfg_valid && (nfr < 2);
                ndone = 1'b0; nerr = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    if (vr[s]) begin
                        if (s == cur) begin
                            bt = mq.pop_front();
                            ndone = bt.ffinal;
                            if (bt.ffinal) nfr--;
                        end else begin
                            nerr = 1'b1;
                        end
                    end
                end
                if (acc) model_push(int'(c_h), int'(c_b), int'(c_e));
                m_done = ndone;
                m_err  = nerr;
                tick();
            end
            cfg_valid = 1'b0; vr = '0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_zero_len();
        test_stray();
        test_end_mode();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
